// File: rtl/RV_EMU_params_pkg.sv
// Shared RV_EMU emulator types: the instruction classes the emulator decodes
// and the per-class CHECKS mask layout used by the check sequencer.
package RV_EMU_params_pkg;

   typedef enum logic [4:0] {
      _ADDI_           = 5'd0,
      _ADD_            = 5'd1,
      _LW_             = 5'd2,
      _SW_             = 5'd3,
      _BEQ_            = 5'd4,
      _JAL_            = 5'd5,
      _CSRRW_          = 5'd6,
      _ECALL_          = 5'd7,
      _FENCE_          = 5'd8,
      _internal_error_ = 5'd31
   } INSTR_TYPE;

   typedef struct packed {
      logic pc;
      logic gpr_wr;
      logic gpr_addr;
      logic gpr_data;
      logic csr_wr;
      logic csr_wr_data;
      logic exc;
      logic mode;
      logic Rs1_addr;
      logic Rs1_data;
      logic Rs2_addr;
      logic Rs2_data;
      logic csr_rd;
      logic csr_rd_data;
      logic events;
   } CHECKS;

endpackage

// File: rtl/rv_emu_check_pkg.sv
// Types, failure codes and the per-instruction check mask for the
// RV_EMU check sequencer.
package rv_emu_check_pkg;
   import RV_EMU_params_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic        gpr_wr;
      logic [4:0]  gpr_addr;
      logic [31:0] gpr_data;
      logic        csr_wr;
      logic [11:0] csr_addr;
      logic [31:0] csr_wr_data;
      logic        exc;
      logic [4:0]  cause;
      logic [31:0] tval;
      logic [1:0]  mode;
   } RETIRE_REC;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STEP,
      ST_COMPARE,
      ST_FAIL
   } state_t;

   localparam logic [3:0] FAIL_NONE     = 4'd0;
   localparam logic [3:0] FAIL_PC       = 4'd1;
   localparam logic [3:0] FAIL_GPR_WR   = 4'd2;
   localparam logic [3:0] FAIL_GPR_ADDR = 4'd3;
   localparam logic [3:0] FAIL_GPR_DATA = 4'd4;
   localparam logic [3:0] FAIL_CSR_WR   = 4'd5;
   localparam logic [3:0] FAIL_CSR_DATA = 4'd6;
   localparam logic [3:0] FAIL_EXC      = 4'd7;
   localparam logic [3:0] FAIL_MODE     = 4'd8;
   localparam logic [3:0] FAIL_TIMEOUT  = 4'd9;
   localparam logic [3:0] FAIL_INTERNAL = 4'd10;

   // Everything is checked by default; a FENCE has no architectural
   // register result, so its gpr fields are left unchecked.
   function automatic CHECKS chk_mask(input INSTR_TYPE t);
      CHECKS m;
      m = '1;
      case (t)
         _FENCE_: begin
            m.gpr_wr   = 1'b0;
            m.gpr_addr = 1'b0;
            m.gpr_data = 1'b0;
         end
         default: ;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/rv_emu_rec_fifo.sv
// Circular FIFO holding retire records until the emulator has been stepped
// for them. A push while full is dropped even when a pop happens the same
// cycle; flush empties it synchronously and wins over push/pop.
module rv_emu_rec_fifo
   import rv_emu_check_pkg::*;
#(
   parameter int  DEPTH = 8,
   parameter type T     = RETIRE_REC
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  T                       din,
   input  logic                   pop,
   output T                       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   T              mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end

   // Record storage needs no reset; only slots below count are ever read.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/rv_emu_check_seq.sv
// Check sequencer: buffers CPU retire records, steps the emulator once per
// record and compares the pair under the emulator's per-instruction mask.
// Any mismatch or emulator timeout latches a sticky failure.
module rv_emu_check_seq
   import RV_EMU_params_pkg::*, rv_emu_check_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic        clk_in,
   input  logic        reset_n,
   input  logic        check_en,
   input  logic        clear_in,
   input  logic        cpu_valid,
   output logic        cpu_ready,
   input  RETIRE_REC   cpu_rec,
   output logic        emu_req,
   input  logic        emu_ack,
   input  RETIRE_REC   emu_rec,
   input  INSTR_TYPE   emu_type,
   output logic        chk_done,
   output logic        fail,
   output logic [3:0]  fail_field,
   output logic [31:0] fail_pc,
   output logic [31:0] checked_cnt
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t                state;
   state_t                state_next;
   logic [CW-1:0]         wait_cnt;
   RETIRE_REC             emu_rec_q;
   INSTR_TYPE             emu_type_q;
   RETIRE_REC             fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                  pop;
   logic                  wait_clr;
   logic                  wait_inc;
   logic                  capture;
   logic                  pass;
   logic                  fail_set;
   logic [3:0]            fail_code;
   logic [3:0]            cmp_code;
   CHECKS                 mask;

   assign cpu_ready = !fifo_full;

   rv_emu_rec_fifo #(
      .DEPTH (DEPTH),
      .T     (RETIRE_REC)
   ) u_fifo (
      .clk   (clk_in),
      .rst_n (reset_n),
      .flush (clear_in),
      .push  (cpu_valid),
      .din   (cpu_rec),
      .pop   (pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Field-by-field comparison of the FIFO head against the captured emulator
   // record; the first masked mismatch in priority order sets the code.
   always_comb begin
      mask     = chk_mask(emu_type_q);
      cmp_code = FAIL_NONE;
      if (emu_type_q == _internal_error_) begin
         cmp_code = FAIL_INTERNAL;
      end else if (mask.pc && (fifo_head.pc != emu_rec_q.pc)) begin
         cmp_code = FAIL_PC;
      end else if (mask.gpr_wr && (fifo_head.gpr_wr != emu_rec_q.gpr_wr)) begin
         cmp_code = FAIL_GPR_WR;
      end else if (mask.gpr_addr && fifo_head.gpr_wr && emu_rec_q.gpr_wr &&
                   (fifo_head.gpr_addr != emu_rec_q.gpr_addr)) begin
         cmp_code = FAIL_GPR_ADDR;
      end else if (mask.gpr_data && fifo_head.gpr_wr && emu_rec_q.gpr_wr &&
                   (fifo_head.gpr_data != emu_rec_q.gpr_data)) begin
         cmp_code = FAIL_GPR_DATA;
      end else if (mask.csr_wr && (fifo_head.csr_wr != emu_rec_q.csr_wr)) begin
         cmp_code = FAIL_CSR_WR;
      end else if (mask.csr_wr_data && fifo_head.csr_wr && emu_rec_q.csr_wr &&
                   ((fifo_head.csr_addr != emu_rec_q.csr_addr) ||
                    (fifo_head.csr_wr_data != emu_rec_q.csr_wr_data))) begin
         cmp_code = FAIL_CSR_DATA;
      end else if (mask.exc &&
                   ((fifo_head.exc != emu_rec_q.exc) ||
                    (fifo_head.exc && ((fifo_head.cause != emu_rec_q.cause) ||
                                       (fifo_head.tval != emu_rec_q.tval))))) begin
         cmp_code = FAIL_EXC;
      end else if (mask.mode && (fifo_head.mode != emu_rec_q.mode)) begin
         cmp_code = FAIL_MODE;
      end
   end

   // State register.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control decode; clear_in overrides every transition.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      wait_clr   = 1'b0;
      wait_inc   = 1'b0;
      capture    = 1'b0;
      pass       = 1'b0;
      fail_set   = 1'b0;
      fail_code  = FAIL_NONE;
      if (clear_in) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if ((fifo_count != '0) && check_en && !fail) begin
                  state_next = ST_STEP;
                  wait_clr   = 1'b1;
               end
            end
            ST_STEP: begin
               if (emu_ack) begin
                  capture    = 1'b1;
                  state_next = ST_COMPARE;
               end else if (wait_cnt == CW'(TIMEOUT)) begin
                  state_next = ST_FAIL;
                  fail_set   = 1'b1;
                  fail_code  = FAIL_TIMEOUT;
               end else begin
                  wait_inc = 1'b1;
               end
            end
            ST_COMPARE: begin
               pop = !fifo_empty;
               if (cmp_code != FAIL_NONE) begin
                  state_next = ST_FAIL;
                  fail_set   = 1'b1;
                  fail_code  = cmp_code;
               end else begin
                  pass       = 1'b1;
                  state_next = ST_IDLE;
               end
            end
            ST_FAIL: begin
               state_next = ST_FAIL;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Emulator wait counter and capture of the emulator's answer.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt   <= '0;
         emu_rec_q  <= '0;
         emu_type_q <= _ADDI_;
      end else begin
         if (wait_clr) begin
            wait_cnt <= '0;
         end else if (wait_inc) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (capture) begin
            emu_rec_q  <= emu_rec;
            emu_type_q <= emu_type;
         end
      end
   end

   // Registered outputs: request level, pass pulse, pass count and the
   // sticky failure record; clear_in returns them all to their reset values.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         emu_req     <= 1'b0;
         chk_done    <= 1'b0;
         fail        <= 1'b0;
         fail_field  <= FAIL_NONE;
         fail_pc     <= '0;
         checked_cnt <= '0;
      end else if (clear_in) begin
         emu_req     <= 1'b0;
         chk_done    <= 1'b0;
         fail        <= 1'b0;
         fail_field  <= FAIL_NONE;
         fail_pc     <= '0;
         checked_cnt <= '0;
      end else begin
         emu_req  <= (state_next == ST_STEP);
         chk_done <= pass;
         if (pass) begin
            checked_cnt <= checked_cnt + 32'd1;
         end
         if (fail_set) begin
            fail       <= 1'b1;
            fail_field <= fail_code;
            fail_pc    <= fifo_head.pc;
         end
      end
   end

endmodule

// File: tb/tb_rv_emu_check_seq.sv
// Directed bench for rv_emu_check_seq: a scripted emulator answers each
// request and every expected value below is worked out by hand.
module tb_rv_emu_check_seq;
   import RV_EMU_params_pkg::*;
   import rv_emu_check_pkg::*;

   logic        clk_in = 1'b0;
   logic        reset_n;
   logic        check_en;
   logic        clear_in;
   logic        cpu_valid;
   logic        cpu_ready;
   RETIRE_REC   cpu_rec;
   logic        emu_req;
   logic        emu_ack;
   RETIRE_REC   emu_rec;
   INSTR_TYPE   emu_type;
   logic        chk_done;
   logic        fail;
   logic [3:0]  fail_field;
   logic [31:0] fail_pc;
   logic [31:0] checked_cnt;

   int total = 0;
   int bad = 0;
   int doneSeen = 0;

   rv_emu_check_seq #(
      .DEPTH   (8),
      .TIMEOUT (64)
   ) dut (
      .clk_in      (clk_in),
      .reset_n     (reset_n),
      .check_en    (check_en),
      .clear_in    (clear_in),
      .cpu_valid   (cpu_valid),
      .cpu_ready   (cpu_ready),
      .cpu_rec     (cpu_rec),
      .emu_req     (emu_req),
      .emu_ack     (emu_ack),
      .emu_rec     (emu_rec),
      .emu_type    (emu_type),
      .chk_done    (chk_done),
      .fail        (fail),
      .fail_field  (fail_field),
      .fail_pc     (fail_pc),
      .checked_cnt (checked_cnt)
   );

   // Free-running clock, period 10.
   always #5 clk_in = ~clk_in;

   // Tally chk_done pulses; each pulse is high for exactly one posedge.
   always @(posedge clk_in) begin
      if (chk_done) doneSeen <= doneSeen + 1;
   end

   // Hard stop in case something hangs beyond every bounded wait.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic RETIRE_REC mkRec(input logic [31:0] pc);
      RETIRE_REC r;
      r          = '0;
      r.pc       = pc;
      r.gpr_wr   = 1'b1;
      r.gpr_addr = 5'd1;
      r.gpr_data = pc + 32'd1;
      r.mode     = 2'b11;
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // Offer one record for one cycle (called at a negedge, returns at the next).
   task automatic applyStimulus(input RETIRE_REC rec);
      cpu_valid = 1'b1;
      cpu_rec   = rec;
      @(negedge clk_in);
      cpu_valid = 1'b0;
   endtask

   // Scripted emulator: wait (bounded) for a request, then ack after delay.
   task automatic emuRespond(input RETIRE_REC rec, input INSTR_TYPE typ, input int delay, input string tag);
      int waited;
      waited = 0;
      while (!emu_req && waited < 200) begin
         @(negedge clk_in);
         waited++;
      end
      checkOutput({tag, "_req"}, {31'd0, emu_req}, 32'd1);
      if (emu_req) begin
         repeat (delay) @(negedge clk_in);
         emu_ack  = 1'b1;
         emu_rec  = rec;
         emu_type = typ;
         @(negedge clk_in);
         emu_ack  = 1'b0;
      end
   endtask

   task automatic pulseClear();
      clear_in = 1'b1;
      @(negedge clk_in);
      clear_in = 1'b0;
   endtask

   // Count cycles where emu_req is high over a window.
   task automatic countReq(input int cycles, output int hits);
      hits = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk_in);
         if (emu_req) hits++;
      end
   endtask

   task automatic runFailCase(input string tag, input RETIRE_REC c, input RETIRE_REC e,
                              input INSTR_TYPE t, input logic [3:0] code);
      applyStimulus(c);
      emuRespond(e, t, 0, tag);
      repeat (2) @(negedge clk_in);
      checkOutput(tag, {28'd0, fail_field}, {28'd0, code});
      pulseClear();
   endtask

   initial begin
      RETIRE_REC c;
      RETIRE_REC cc;
      RETIRE_REC ce;
      RETIRE_REC e;
      int base;
      int hits;
      int waited;

      reset_n   = 1'b0;
      check_en  = 1'b1;
      clear_in  = 1'b0;
      cpu_valid = 1'b0;
      cpu_rec   = '0;
      emu_ack   = 1'b0;
      emu_rec   = '0;
      emu_type  = _ADDI_;
      repeat (2) @(negedge clk_in);
      reset_n = 1'b1;
      @(negedge clk_in);

      checkOutput("rst_ready", {31'd0, cpu_ready}, 32'd1);
      checkOutput("rst_req", {31'd0, emu_req}, 32'd0);
      checkOutput("rst_done", {31'd0, chk_done}, 32'd0);
      checkOutput("rst_fail", {31'd0, fail}, 32'd0);
      checkOutput("rst_field", {28'd0, fail_field}, 32'd0);
      checkOutput("rst_pc", fail_pc, 32'd0);
      checkOutput("rst_cnt", checked_cnt, 32'd0);

      // Three matching ADDI records, emulator acking 2 cycles after request.
      base = doneSeen;
      applyStimulus(mkRec(32'h100));
      checkOutput("lat_req_t1", {31'd0, emu_req}, 32'd0);
      applyStimulus(mkRec(32'h104));
      checkOutput("lat_req_t2", {31'd0, emu_req}, 32'd1);
      applyStimulus(mkRec(32'h108));
      emuRespond(mkRec(32'h100), _ADDI_, 2, "addi0");
      checkOutput("ack_req_low", {31'd0, emu_req}, 32'd0);
      checkOutput("ack_done_early", {31'd0, chk_done}, 32'd0);
      @(negedge clk_in);
      checkOutput("ack_done", {31'd0, chk_done}, 32'd1);
      emuRespond(mkRec(32'h104), _ADDI_, 2, "addi1");
      emuRespond(mkRec(32'h108), _ADDI_, 2, "addi2");
      repeat (4) @(negedge clk_in);
      checkOutput("addi_pulses", doneSeen - base, 32'd3);
      checkOutput("addi_cnt", checked_cnt, 32'd3);
      checkOutput("addi_fail", {31'd0, fail}, 32'd0);

      // ADD with differing gpr_data fails with code 4 and stops stepping.
      c = mkRec(32'h200);
      c.gpr_data = 32'h5;
      e = c;
      e.gpr_data = 32'h6;
      applyStimulus(c);
      emuRespond(e, _ADD_, 1, "add");
      repeat (2) @(negedge clk_in);
      checkOutput("add_fail", {31'd0, fail}, 32'd1);
      checkOutput("add_field", {28'd0, fail_field}, 32'd4);
      checkOutput("add_pc", fail_pc, 32'h200);
      checkOutput("add_cnt", checked_cnt, 32'd3);
      applyStimulus(mkRec(32'h204));
      countReq(10, hits);
      checkOutput("fail_noreq", hits, 32'd0);

      // clear_in during FAIL restores reset values and flushes the FIFO.
      pulseClear();
      checkOutput("clr_fail", {31'd0, fail}, 32'd0);
      checkOutput("clr_field", {28'd0, fail_field}, 32'd0);
      checkOutput("clr_pc", fail_pc, 32'd0);
      checkOutput("clr_cnt", checked_cnt, 32'd0);
      checkOutput("clr_ready", {31'd0, cpu_ready}, 32'd1);
      countReq(5, hits);
      checkOutput("clr_flushed", hits, 32'd0);

      // FENCE ignores gpr differences.
      base = doneSeen;
      c = mkRec(32'h300);
      e = c;
      e.gpr_wr   = 1'b0;
      e.gpr_addr = 5'd3;
      e.gpr_data = 32'h7;
      applyStimulus(c);
      emuRespond(e, _FENCE_, 2, "fence");
      repeat (2) @(negedge clk_in);
      checkOutput("fence_fail", {31'd0, fail}, 32'd0);
      checkOutput("fence_cnt", checked_cnt, 32'd1);
      checkOutput("fence_pulse", doneSeen - base, 32'd1);
      pulseClear();

      // Failure-code table, each case starting from a cleared, empty sequencer.
      c = mkRec(32'h500);
      e = c; e.pc = 32'h504;
      runFailCase("code_pc", c, e, _ADDI_, 4'd1);
      e = c; e.gpr_wr = 1'b0;
      runFailCase("code_gpr_wr", c, e, _ADDI_, 4'd2);
      e = c; e.gpr_addr = 5'd7;
      runFailCase("code_gpr_addr", c, e, _ADDI_, 4'd3);
      cc = c; cc.csr_wr = 1'b1; cc.csr_addr = 12'h300; cc.csr_wr_data = 32'h1;
      e = cc; e.csr_addr = 12'h305;
      runFailCase("code_csr_addr", cc, e, _CSRRW_, 4'd6);
      e = cc; e.csr_wr = 1'b0;
      runFailCase("code_csr_wr", cc, e, _CSRRW_, 4'd5);
      ce = c; ce.exc = 1'b1; ce.cause = 5'd2; ce.tval = 32'h1234;
      e = ce; e.cause = 5'd3;
      runFailCase("code_exc_cause", ce, e, _ECALL_, 4'd7);
      e = c; e.cause = 5'd5;
      runFailCase("code_noexc_cause", c, e, _ADDI_, 4'd0);
      e = c; e.mode = 2'b00;
      runFailCase("code_mode", c, e, _ADDI_, 4'd8);
      e = c;
      runFailCase("code_internal", c, e, _internal_error_, 4'd10);
      e = c; e.pc = 32'h508; e.mode = 2'b00;
      runFailCase("code_priority", c, e, _ADDI_, 4'd1);
      e = c; e.gpr_data = 32'd99;
      runFailCase("code_fence_data", c, e, _FENCE_, 4'd0);
      e = c; e.pc = 32'h50c;
      runFailCase("code_fence_pc", c, e, _FENCE_, 4'd1);

      // Emulator never acks: fail appears 65 cycles after emu_req rises.
      applyStimulus(mkRec(32'h600));
      waited = 0;
      while (!emu_req && waited < 20) begin
         @(negedge clk_in);
         waited++;
      end
      checkOutput("to_req", {31'd0, emu_req}, 32'd1);
      repeat (64) @(negedge clk_in);
      checkOutput("to_before", {31'd0, fail}, 32'd0);
      @(negedge clk_in);
      checkOutput("to_fail", {31'd0, fail}, 32'd1);
      checkOutput("to_field", {28'd0, fail_field}, 32'd9);
      checkOutput("to_pc", fail_pc, 32'h600);
      checkOutput("to_req_low", {31'd0, emu_req}, 32'd0);
      pulseClear();

      // check_en low: 8 pushes fill the FIFO, the 9th is dropped.
      check_en = 1'b0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(mkRec(32'h700 + 32'(4 * i)));
         if (i == 6) checkOutput("fill_ready7", {31'd0, cpu_ready}, 32'd1);
         if (i == 7) checkOutput("fill_ready8", {31'd0, cpu_ready}, 32'd0);
      end
      checkOutput("fill_noreq", {31'd0, emu_req}, 32'd0);
      base = doneSeen;
      check_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         emuRespond(mkRec(32'h700 + 32'(4 * i)), _ADDI_, 1, "drain");
      end
      repeat (3) @(negedge clk_in);
      checkOutput("drain_pulses", doneSeen - base, 32'd8);
      checkOutput("drain_cnt", checked_cnt, 32'd8);
      checkOutput("drain_fail", {31'd0, fail}, 32'd0);
      checkOutput("drain_ready", {31'd0, cpu_ready}, 32'd1);
      countReq(8, hits);
      checkOutput("drain_ninth", hits, 32'd0);

      // Asynchronous reset while a request is outstanding.
      applyStimulus(mkRec(32'h800));
      waited = 0;
      while (!emu_req && waited < 20) begin
         @(negedge clk_in);
         waited++;
      end
      checkOutput("arst_req_pre", {31'd0, emu_req}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("arst_req", {31'd0, emu_req}, 32'd0);
      checkOutput("arst_cnt", checked_cnt, 32'd0);
      checkOutput("arst_ready", {31'd0, cpu_ready}, 32'd1);
      checkOutput("arst_fail", {31'd0, fail}, 32'd0);
      @(negedge clk_in);
      reset_n = 1'b1;
      countReq(5, hits);
      checkOutput("arst_flushed", hits, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
